// File: rtl/ddr_cmd_pkg.sv
// rtl/ddr_cmd_pkg.sv - Bank command bit positions and sequencer state encoding.
package ddr_cmd_pkg;

    localparam int CMD_W   = 19;
    localparam int CMD_ACT = 18;
    localparam int CMD_PRE = 7;
    localparam int CMD_RD  = 5;
    localparam int CMD_WR  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPEN,
        ST_PRE,
        ST_TRP_WAIT,
        ST_ACT,
        ST_TRCD_WAIT,
        ST_BURST
    } seq_state_e;

    function automatic logic [CMD_W-1:0] cmd_onehot(input int unsigned idx);
        cmd_onehot = {{(CMD_W-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/timing_counter.sv
// rtl/timing_counter.sv - Loadable saturating down-counter with halt freeze and zero flag.
module timing_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    input  logic             halt_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!halt_i) begin
            if (load_i) begin
                cnt_d = load_val_i;
            end else if (dec_i && (cnt_q != '0)) begin
                cnt_d = cnt_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bank_cmd_sequencer.sv
// rtl/bank_cmd_sequencer.sv - Open-page per-bank PRE/ACT/RD/WR sequencer with tRP/tRCD/tRAS timing.
module bank_cmd_sequencer
    import ddr_cmd_pkg::*;
#(
    parameter int ROWS  = 131072,
    parameter int COLS  = 1024,
    parameter int BL    = 8,
    parameter int T_RCD = 3,
    parameter int T_RP  = 3,
    parameter int T_RAS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     halt_in,
    input  logic                     req_valid,
    input  logic                     req_write,
    input  logic [$clog2(ROWS)-1:0]  req_row,
    input  logic [$clog2(COLS)-1:0]  req_col,
    output logic                     req_ready,
    output logic                     done,
    output logic [CMD_W-1:0]         commands,
    output logic [$clog2(ROWS)-1:0]  row,
    output logic [$clog2(COLS)-1:0]  column,
    output logic                     halt
);

    localparam int RW        = $clog2(ROWS);
    localparam int CW        = $clog2(COLS);
    localparam int BURST_CYC = BL / 2;
    localparam int SEQ_MAX_A = (T_RP - 1) > (T_RCD - 1) ? (T_RP - 1) : (T_RCD - 1);
    localparam int SEQ_MAX   = SEQ_MAX_A > (BURST_CYC - 1) ? SEQ_MAX_A : (BURST_CYC - 1);
    localparam int SEQ_W     = (SEQ_MAX < 1) ? 1 : $clog2(SEQ_MAX + 1);
    localparam int RAS_W     = (T_RAS < 2) ? 1 : $clog2(T_RAS);

    seq_state_e       state_q, state_d;
    logic             open_valid_q, open_valid_d;
    logic [RW-1:0]    open_row_q, open_row_d;
    logic [RW-1:0]    cap_row_q, cap_row_d;
    logic [CW-1:0]    cap_col_q, cap_col_d;
    logic             cap_wr_q, cap_wr_d;
    logic             pend_q, pend_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic [RW-1:0]    row_q, row_d;
    logic [CW-1:0]    col_q, col_d;
    logic             done_q, done_d;

    logic             seq_load, seq_zero;
    logic [SEQ_W-1:0] seq_load_val;
    logic             ras_load, ras_zero;
    logic             accept, row_hit;

    // A miss accepted before tRAS has elapsed parks in OPEN with pend_q set.
    assign req_ready = !reset && !halt_in &&
                       ((state_q == ST_IDLE) || ((state_q == ST_OPEN) && !pend_q));
    assign accept    = req_valid && req_ready;
    assign row_hit   = open_valid_q && (req_row == open_row_q);

    always_comb begin
        state_d      = state_q;
        open_valid_d = open_valid_q;
        open_row_d   = open_row_q;
        cap_row_d    = cap_row_q;
        cap_col_d    = cap_col_q;
        cap_wr_d     = cap_wr_q;
        pend_d       = pend_q;
        cmd_d        = '0;
        row_d        = row_q;
        col_d        = col_q;
        done_d       = 1'b0;
        seq_load     = 1'b0;
        seq_load_val = '0;
        ras_load     = 1'b0;

        if (!halt_in) begin
            if (accept) begin
                cap_row_d = req_row;
                cap_col_d = req_col;
                cap_wr_d  = req_write;
            end

            case (state_q)
                ST_IDLE: begin
                    if (accept) state_d = ST_ACT;
                end
                ST_OPEN: begin
                    if (pend_q) begin
                        if (ras_zero) begin
                            state_d = ST_PRE;
                            pend_d  = 1'b0;
                        end
                    end else if (accept) begin
                        if (row_hit)       state_d = ST_BURST;
                        else if (ras_zero) state_d = ST_PRE;
                        else               pend_d  = 1'b1;
                    end
                end
                ST_PRE, ST_TRP_WAIT: state_d = seq_zero ? ST_ACT : ST_TRP_WAIT;
                ST_ACT, ST_TRCD_WAIT: state_d = seq_zero ? ST_BURST : ST_TRCD_WAIT;
                ST_BURST: begin
                    if (seq_zero) begin
                        state_d = ST_OPEN;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Phase timers are loaded on entry; the entered state is what issues next cycle.
            if (state_d != state_q) begin
                case (state_d)
                    ST_PRE: begin
                        seq_load     = 1'b1;
                        seq_load_val = SEQ_W'(T_RP - 1);
                        open_valid_d = 1'b0;
                    end
                    ST_ACT: begin
                        seq_load     = 1'b1;
                        seq_load_val = SEQ_W'(T_RCD - 1);
                        ras_load     = 1'b1;
                        open_valid_d = 1'b1;
                        open_row_d   = cap_row_d;
                    end
                    ST_BURST: begin
                        seq_load     = 1'b1;
                        seq_load_val = SEQ_W'(BURST_CYC - 1);
                    end
                    default: ;
                endcase
            end

            case (state_d)
                ST_PRE: cmd_d = cmd_onehot(CMD_PRE);
                ST_ACT: begin
                    cmd_d = cmd_onehot(CMD_ACT);
                    row_d = cap_row_d;
                end
                ST_BURST: begin
                    cmd_d = cap_wr_d ? cmd_onehot(CMD_WR) : cmd_onehot(CMD_RD);
                    row_d = open_row_d;
                    col_d = cap_col_d;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            open_valid_q <= 1'b0;
            open_row_q   <= '0;
            cap_row_q    <= '0;
            cap_col_q    <= '0;
            cap_wr_q     <= 1'b0;
            pend_q       <= 1'b0;
            cmd_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            open_valid_q <= open_valid_d;
            open_row_q   <= open_row_d;
            cap_row_q    <= cap_row_d;
            cap_col_q    <= cap_col_d;
            cap_wr_q     <= cap_wr_d;
            pend_q       <= pend_d;
            cmd_q        <= cmd_d;
            row_q        <= row_d;
            col_q        <= col_d;
            done_q       <= done_d;
        end
    end

    timing_counter #(.WIDTH(SEQ_W)) u_seq_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (seq_load),
        .load_val_i (seq_load_val),
        .dec_i      (1'b1),
        .halt_i     (halt_in),
        .zero_o     (seq_zero)
    );

    // Counts down from ACT while the row is open; zero means PRE is legal.
    timing_counter #(.WIDTH(RAS_W)) u_ras_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (ras_load),
        .load_val_i (RAS_W'(T_RAS - 1)),
        .dec_i      (open_valid_q),
        .halt_i     (halt_in),
        .zero_o     (ras_zero)
    );

    assign commands = cmd_q;
    assign row      = row_q;
    assign column   = col_q;
    assign done     = done_q;
    assign halt     = halt_in;

endmodule
